// File: rtl/snn_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snn_run_sequencer
// Function : Runs one inference of the 3-layer spiking network: loads the
//            input vector, executes N timesteps, counts output spikes and
//            picks the winning class by argmax.
// Options  : SNN_RUN_SEQUENCER_ABORT_EN adds an abort input.
// Revision : 1.0 - initial release
// ============================================================================
module snn_run_sequencer #(
    parameter int OUTPUTS       = 8,
    parameter int INPUT_BYTES   = 2,
    parameter int STEP_BITS     = 8,
    parameter int COUNT_BITS    = 8,
    parameter int SPIKE_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
`ifdef SNN_RUN_SEQUENCER_ABORT_EN
    input  logic                          abort,
`endif
    input  logic                          start,
    input  logic [STEP_BITS-1:0]          num_steps,
    output logic                          busy,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic [7:0]                    net_data,
    output logic                          net_load,
    output logic                          net_execute,
    input  logic [OUTPUTS-1:0]            net_spikes,
    output logic                          done,
    output logic [$clog2(OUTPUTS)-1:0]    winner,
    output logic [COUNT_BITS-1:0]         winner_count,
    output logic [OUTPUTS*COUNT_BITS-1:0] counts
);

    localparam int c_WIN_W = $clog2(OUTPUTS);
    localparam int c_BI_W  = (INPUT_BYTES > 1) ? $clog2(INPUT_BYTES) : 1;
    localparam int c_DR_W  = (SPIKE_LATENCY > 0) ? $clog2(SPIKE_LATENCY + 1) : 1;

    localparam logic [c_BI_W-1:0]     c_LAST_BYTE  = c_BI_W'(INPUT_BYTES - 1);
    localparam logic [c_WIN_W-1:0]    c_LAST_IDX   = c_WIN_W'(OUTPUTS - 1);
    localparam logic [c_DR_W-1:0]     c_DRAIN_INIT = c_DR_W'(SPIKE_LATENCY);
    localparam logic [COUNT_BITS-1:0] c_CNT_MAX    = {COUNT_BITS{1'b1}};

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_RUN    = 3'd2;
    localparam logic [2:0] c_ST_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_ARGMAX = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    logic [2:0]                    r_state;
    logic [2:0]                    w_state_next;
    logic [STEP_BITS-1:0]          r_steps;
    logic [c_BI_W-1:0]             r_byte_idx;
    logic [c_DR_W-1:0]             r_drain;
    logic [c_WIN_W-1:0]            r_idx;
    logic [SPIKE_LATENCY-1:0]      r_vpipe;
    logic [7:0]                    r_net_data;
    logic                          r_net_load;
    logic                          r_net_execute;
    logic [c_WIN_W-1:0]            r_winner;
    logic [COUNT_BITS-1:0]         r_winner_count;
    logic [OUTPUTS*COUNT_BITS-1:0] r_counts;

    logic                          w_abort;
    logic                          w_accept;
    logic                          w_last_byte;
    logic [COUNT_BITS-1:0]         w_scan_cnt;

`ifdef SNN_RUN_SEQUENCER_ABORT_EN
    assign w_abort = abort && (r_state != c_ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept    = in_valid && (r_state == c_ST_LOAD);
    assign w_last_byte = w_accept && (r_byte_idx == c_LAST_BYTE);
    assign w_scan_cnt  = r_counts[r_idx*COUNT_BITS +: COUNT_BITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_state_next = c_ST_LOAD;
            c_ST_LOAD:   if (w_last_byte) w_state_next = (r_steps == '0) ? c_ST_ARGMAX : c_ST_RUN;
            c_ST_RUN:    if (r_steps == STEP_BITS'(1)) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN:  if (r_drain == '0) w_state_next = c_ST_ARGMAX;
            c_ST_ARGMAX: if (r_idx == c_LAST_IDX) w_state_next = c_ST_DONE;
            c_ST_DONE:   w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
        if (w_abort) w_state_next = c_ST_IDLE;
    end

    // net_execute is registered one cycle behind RUN, so DRAIN holds one
    // cycle beyond the spike latency before the scan reads final counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_steps        <= '0;
            r_byte_idx     <= '0;
            r_drain        <= '0;
            r_idx          <= '0;
            r_vpipe        <= '0;
            r_net_data     <= '0;
            r_net_load     <= 1'b0;
            r_net_execute  <= 1'b0;
            r_winner       <= '0;
            r_winner_count <= '0;
            r_counts       <= '0;
        end else begin
            r_net_load    <= 1'b0;
            r_net_execute <= (r_state == c_ST_RUN);
            r_vpipe       <= (r_vpipe << 1) | SPIKE_LATENCY'(r_net_execute);
            r_drain       <= c_DRAIN_INIT;
            r_idx         <= '0;

            for (int i = 0; i < OUTPUTS; i++) begin
                if (r_vpipe[SPIKE_LATENCY-1] && net_spikes[i] &&
                    (r_counts[i*COUNT_BITS +: COUNT_BITS] != c_CNT_MAX)) begin
                    r_counts[i*COUNT_BITS +: COUNT_BITS] <=
                        r_counts[i*COUNT_BITS +: COUNT_BITS] + COUNT_BITS'(1);
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_steps        <= num_steps;
                        r_byte_idx     <= '0;
                        r_counts       <= '0;
                        r_winner       <= '0;
                        r_winner_count <= '0;
                    end
                end
                c_ST_LOAD: begin
                    if (w_accept) begin
                        r_net_data <= in_data;
                        r_net_load <= 1'b1;
                        r_byte_idx <= r_byte_idx + c_BI_W'(1);
                    end
                end
                c_ST_RUN: begin
                    r_steps <= r_steps - STEP_BITS'(1);
                end
                c_ST_DRAIN: begin
                    r_drain <= r_drain - c_DR_W'(1);
                end
                c_ST_ARGMAX: begin
                    // strict compare keeps the lowest index on ties
                    if (w_scan_cnt > r_winner_count) begin
                        r_winner       <= r_idx;
                        r_winner_count <= w_scan_cnt;
                    end
                    r_idx <= r_idx + c_WIN_W'(1);
                end
                default: begin
                end
            endcase

            if (w_abort) begin
                r_net_load     <= 1'b0;
                r_net_execute  <= 1'b0;
                r_vpipe        <= '0;
                r_counts       <= '0;
                r_winner       <= '0;
                r_winner_count <= '0;
            end
        end
    end

    assign busy         = (r_state != c_ST_IDLE);
    assign in_ready     = (r_state == c_ST_LOAD);
    assign done         = (r_state == c_ST_DONE);
    assign net_data     = r_net_data;
    assign net_load     = r_net_load;
    assign net_execute  = r_net_execute;
    assign winner       = r_winner;
    assign winner_count = r_winner_count;
    assign counts       = r_counts;

endmodule
`default_nettype wire

// File: tb/tb_snn_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_run_sequencer
// Function : Scoreboard bench for snn_run_sequencer with an emulated network
//            core that replays a per-timestep spike pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_run_sequencer;

    localparam int OUTPUTS       = 8;
    localparam int INPUT_BYTES   = 2;
    localparam int STEP_BITS     = 8;
    localparam int COUNT_BITS    = 8;
    localparam int SPIKE_LATENCY = 3;
    localparam int c_W           = OUTPUTS * COUNT_BITS;
    localparam int c_PAT_LEN     = 300;

    logic                   clk        = 1'b0;
    logic                   reset      = 1'b1;
    logic                   start      = 1'b0;
    logic [STEP_BITS-1:0]   num_steps  = '0;
    logic                   in_valid   = 1'b0;
    logic [7:0]             in_data    = '0;
    logic [OUTPUTS-1:0]     net_spikes = '0;
    logic                   busy;
    logic                   in_ready;
    logic [7:0]             net_data;
    logic                   net_load;
    logic                   net_execute;
    logic                   done;
    logic [$clog2(OUTPUTS)-1:0] winner;
    logic [COUNT_BITS-1:0]  winner_count;
    logic [c_W-1:0]         counts;
`ifdef SNN_RUN_SEQUENCER_ABORT_EN
    logic                   abort = 1'b0;
`endif

    snn_run_sequencer #(
        .OUTPUTS(OUTPUTS), .INPUT_BYTES(INPUT_BYTES), .STEP_BITS(STEP_BITS),
        .COUNT_BITS(COUNT_BITS), .SPIKE_LATENCY(SPIKE_LATENCY)
    ) u_dut (
        .clk(clk), .reset(reset),
`ifdef SNN_RUN_SEQUENCER_ABORT_EN
        .abort(abort),
`endif
        .start(start), .num_steps(num_steps), .busy(busy),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .net_data(net_data), .net_load(net_load), .net_execute(net_execute),
        .net_spikes(net_spikes), .done(done), .winner(winner),
        .winner_count(winner_count), .counts(counts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [c_W-1:0]              cnt;
        logic [$clog2(OUTPUTS)-1:0]  win;
        logic [COUNT_BITS-1:0]       wc;
        int                          n;
        int                          acc;
        int                          lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] pat[c_PAT_LEN];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: sum the first n timestep patterns, saturate, first-max argmax.
    function automatic exp_t model(input int n);
        exp_t e;
        int   cnt[OUTPUTS];
        int   best;
        e.cnt = '0; e.win = '0; e.wc = '0; e.n = n; e.acc = 0; e.lat = -1;
        best = 0;
        for (int i = 0; i < OUTPUTS; i++) cnt[i] = 0;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < OUTPUTS; i++)
                if (pat[k][i] && cnt[i] < (1 << COUNT_BITS) - 1) cnt[i]++;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (cnt[i] > best) begin
                best  = cnt[i];
                e.win = ($clog2(OUTPUTS))'(i);
            end
            e.cnt[i*COUNT_BITS +: COUNT_BITS] = COUNT_BITS'(cnt[i]);
        end
        e.wc = COUNT_BITS'(best);
        return e;
    endfunction

    // Network core stand-in: the k-th execute cycle shows pat[k] on
    // net_spikes SPIKE_LATENCY cycles later; other cycles carry noise.
    logic [SPIKE_LATENCY:0] hist = '0;
    int                     pidx = 0;
    always @(negedge clk) begin
        if (net_load) pidx = 0;
        hist = {hist[SPIKE_LATENCY-1:0], net_execute};
        if (hist[SPIKE_LATENCY]) begin
            net_spikes = pat[pidx % c_PAT_LEN];
            pidx++;
        end else begin
            net_spikes = OUTPUTS'($urandom);
        end
    end

    exp_t mon_e;
    int   exec_cnt   = 0;
    int   first_exec = -1;
    int   last_load  = -1;
    always @(negedge clk) begin
        if (reset) begin
            exec_cnt   = 0;
            first_exec = -1;
        end else begin
            if (net_load) begin
                if (byte_q.size() == 0) check("net_load_extra", c_W'(net_load), c_W'(0));
                else check("net_data", c_W'(net_data), c_W'(byte_q.pop_front()));
                last_load = cyc;
            end
            if (net_execute) begin
                if (first_exec < 0) first_exec = cyc;
                exec_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_extra", c_W'(done), c_W'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("counts", counts, mon_e.cnt);
                    check("winner", c_W'(winner), c_W'(mon_e.win));
                    check("winner_count", c_W'(winner_count), c_W'(mon_e.wc));
                    check("exec_cycles", c_W'(exec_cnt), c_W'(mon_e.n));
                    if (mon_e.n > 0) check("exec_start", c_W'(first_exec), c_W'(last_load + 1));
                    if (mon_e.lat >= 0) check("done_latency", c_W'(cyc - mon_e.acc), c_W'(mon_e.lat));
                end
                exec_cnt   = 0;
                first_exec = -1;
            end
        end
    end

    task automatic fill_pat(input bit rnd, input logic [7:0] v);
        for (int k = 0; k < c_PAT_LEN; k++) pat[k] = rnd ? 8'($urandom) : v;
    endtask

    task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1, input int gap, output int acc);
        int k;
        acc = 0;
        for (int b = 0; b < INPUT_BYTES; b++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                check("in_ready_stall", c_W'(in_ready), c_W'(1));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = (b == 0) ? b0 : b1;
            byte_q.push_back(in_data);
            k = 0;
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) check("in_ready_timeout", c_W'(in_ready), c_W'(1));
            acc = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_inf(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input int gap, input bit stray);
        exp_t e;
        int   acc;
        int   k;
        e = model(n);
        @(negedge clk);
        start     = 1'b1;
        num_steps = STEP_BITS'(n);
        in_valid  = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        num_steps = STEP_BITS'($urandom);
        check("busy_load", c_W'(busy), c_W'(1));
        load_bytes(b0, b1, gap, acc);
        e.acc = acc;
        e.lat = (n > 0) ? n + SPIKE_LATENCY + OUTPUTS + 2 : -1;
        exp_q.push_back(e);
        if (stray) begin
            @(negedge clk);
            start     = 1'b1;
            num_steps = 8'd7;
            check("busy_run", c_W'(busy), c_W'(1));
            check("in_ready_run", c_W'(in_ready), c_W'(0));
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (exp_q.size() != 0 && k < n + 100) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        if (exp_q.size() != 0) begin
            check("done_timeout", c_W'(exp_q.size()), c_W'(0));
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        int acc;
        int seen;
        int k;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", c_W'(busy), c_W'(0));
        check("rst_in_ready", c_W'(in_ready), c_W'(0));
        check("rst_net_load", c_W'(net_load), c_W'(0));
        check("rst_net_execute", c_W'(net_execute), c_W'(0));
        check("rst_done", c_W'(done), c_W'(0));
        check("rst_net_data", c_W'(net_data), c_W'(0));
        check("rst_winner", c_W'(winner), c_W'(0));
        check("rst_winner_count", c_W'(winner_count), c_W'(0));
        check("rst_counts", counts, c_W'(0));
        reset = 1'b0;

        fill_pat(1'b1, 8'h00);
        run_inf(4, 8'h34, 8'h12, 0, 1'b0);

        fill_pat(1'b0, 8'h04);
        run_inf(10, 8'($urandom), 8'($urandom), 0, 1'b0);

        fill_pat(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) pat[i] = 8'h22;
        for (int i = 6; i < 10; i++) pat[i] = 8'h08;
        for (int i = 10; i < 12; i++) pat[i] = 8'h01;
        run_inf(12, 8'($urandom), 8'($urandom), 0, 1'b0);

        fill_pat(1'b0, 8'hFF);
        run_inf(255, 8'($urandom), 8'($urandom), 0, 1'b0);

        fill_pat(1'b1, 8'h00);
        run_inf(0, 8'($urandom), 8'($urandom), 0, 1'b0);

        fill_pat(1'b1, 8'h00);
        run_inf(9, 8'($urandom), 8'($urandom), 20, 1'b1);

        // reset during RUN after five execute cycles
        fill_pat(1'b1, 8'h00);
        @(negedge clk);
        start     = 1'b1;
        num_steps = 8'd20;
        @(negedge clk);
        start = 1'b0;
        load_bytes(8'($urandom), 8'($urandom), 0, acc);
        seen = 0;
        k    = 0;
        while (seen < 5 && k < 100) begin
            @(negedge clk);
            k++;
            if (net_execute) seen++;
        end
        if (seen < 5) check("exec_timeout", c_W'(seen), c_W'(5));
        reset = 1'b1;
        @(negedge clk);
        check("midrun_rst_busy", c_W'(busy), c_W'(0));
        check("midrun_rst_execute", c_W'(net_execute), c_W'(0));
        check("midrun_rst_counts", counts, c_W'(0));
        check("midrun_rst_done", c_W'(done), c_W'(0));
        check("midrun_rst_winner_count", c_W'(winner_count), c_W'(0));
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // start coinciding with reset is dropped
        reset     = 1'b1;
        start     = 1'b1;
        num_steps = 8'd5;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", c_W'(busy), c_W'(0));
        @(negedge clk);
        check("rst_start_busy2", c_W'(busy), c_W'(0));

        for (int r = 0; r < 12; r++) begin
            fill_pat(1'b1, 8'h00);
            n = $urandom_range(0, 40);
            run_inf(n, 8'($urandom), 8'($urandom), $urandom_range(0, 3),
                    (n >= 3) && ($urandom_range(0, 1) == 1));
        end

        repeat (10) @(negedge clk);
        check("exp_q_empty", c_W'(exp_q.size()), c_W'(0));
        check("byte_q_empty", c_W'(byte_q.size()), c_W'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got cycle %0d required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/snn_run_sequencer.md
Name: snn_run_sequencer

Overview:
Controller that sequences one inference of the 3-layer spiking network.
- Streams a host input vector into the network input register.
- Drives the network execute enable for a programmed number of timesteps.
- Accumulates per-output-neuron spike counts and selects the winning class by argmax.
- Sits between the host byte interface and the network core, replacing manual toggling of the execute/input-mode pins.

Parameters:
OUTPUTS, 8, number of output-layer neurons observed.
INPUT_BYTES, 2, bytes per input vector (16 inputs).
STEP_BITS, 8, width of the timestep count.
COUNT_BITS, 8, width of each per-neuron spike counter.
SPIKE_LATENCY, 3, cycles from an execute cycle to its effect on net_spikes (2 inter-layer registers + neuron register).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin inference; sampled only in IDLE
num_steps  in  STEP_BITS  timesteps to run; latched on accepted start
busy  out  1  high in every state except IDLE
in_valid  in  1  host byte valid
in_data  in  8  host byte, little-endian order (first byte = inputs[7:0])
in_ready  out  1  high only in LOAD
net_data  out  8  byte to network input shift register
net_load  out  1  one-cycle write strobe for net_data
net_execute  out  1  network enable (execute)
net_spikes  in  OUTPUTS  output-layer spikes
done  out  1  one-cycle pulse, inference complete
winner  out  $clog2(OUTPUTS)  argmax index
winner_count  out  COUNT_BITS  spike count of winner
counts  out  OUTPUTS*COUNT_BITS  flattened counters; neuron i at [i*COUNT_BITS +: COUNT_BITS]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port reset.
- Reset values: state IDLE. busy, in_ready, net_load, net_execute, done = 0. net_data, winner, winner_count, all counts = 0.
- States: IDLE -> LOAD -> RUN -> DRAIN -> ARGMAX -> DONE -> IDLE.

IDLE:
- start=1 latches num_steps, clears all counts, winner and winner_count, then goes to LOAD.
- start is ignored in every other state.

LOAD:
- in_ready=1. Byte index counter starts at 0.
- Each in_valid&in_ready registers in_data into net_data and pulses net_load the next cycle.
- After INPUT_BYTES accepted bytes: go to RUN, or to ARGMAX if the latched num_steps==0.
- in_valid low stalls indefinitely. in_valid outside LOAD has no effect.

RUN:
- net_execute=1 for exactly num_steps consecutive cycles, tracked by a down-counter; then DRAIN.
- No cycle gap between the last net_load and the first execute cycle.

Spike valid pipeline and counting:
- A SPIKE_LATENCY-deep shift register carries net_execute.
- While its tail bit is 1, each counts[i] increments when net_spikes[i]=1.
- Counters saturate at 2^COUNT_BITS-1; no wrap.

DRAIN:
- net_execute=0 for SPIKE_LATENCY cycles so in-flight spikes are still counted; then ARGMAX.

ARGMAX:
- Sequential scan, one neuron per cycle, index 0..OUTPUTS-1: OUTPUTS cycles.
- Replace the candidate only on strictly greater count, so ties go to the lowest index.
- All-zero counts give winner=0, winner_count=0.

DONE:
- done=1 for one cycle, then IDLE.
- winner, winner_count and counts hold until the next accepted start.

Timing and edge cases:
- Total latency from the last accepted byte to done = num_steps + SPIKE_LATENCY + OUTPUTS + 2 cycles (±0).
- Reset asserted in any state: next cycle is IDLE with reset values; no done pulse; the partially loaded vector is discarded.
- start and reset in the same cycle: reset wins.

Optional Feature:
Macro SNN_RUN_SEQUENCER_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in any non-IDLE state forces IDLE on the next cycle.
  - net_execute and net_load drop that cycle; no done pulse.
  - Counters, winner and winner_count are cleared.
  - abort in IDLE is ignored.
- Undefined: no abort port; an inference always runs to DONE unless reset.

Test Plan:
1. Reset mid-RUN after 5 steps -> next cycle busy=0, net_execute=0, counts=0, no done.
2. start num_steps=4; bytes 0x34,0x12 -> net_load pulses carry 0x34 then 0x12; net_execute high exactly 4 cycles; done exactly 4+3+8+2 cycles after the second byte accepted.
3. net_spikes=8'b0000_0100 on every counted cycle, num_steps=10 -> counts[2]=10, others 0, winner=2, winner_count=10.
4. Tie: neurons 1 and 5 each spike 6 times -> winner=1, winner_count=6.
5. num_steps=255 with net_spikes all ones, COUNT_BITS=8 -> every count=255 (saturated), winner=0; num_steps=0 -> net_execute never high, done with winner=0, counts zero.
6. in_valid held low for 20 cycles in LOAD, start pulsed during RUN -> sequencer stalls with in_ready=1; stray start has no effect; one done per accepted start.
